// File: rtl/alarm_ctrl_if.sv
// Alarm controller bus: time/alarm words, tick pulses, buttons in; buzzer and status out.
interface alarm_ctrl_if;
  logic [15:0] timeData;
  logic [15:0] alarmData;
  logic        halfSecond;
  logic        oneMinute;
  logic        alarmEnable;
  logic        snoozeBtn;
  logic        stopBtn;
  logic        buzzer;
  logic        ringing;
  logic        snoozing;
  logic [3:0]  snoozeNum;

  modport master (
    output timeData, alarmData, halfSecond, oneMinute, alarmEnable, snoozeBtn, stopBtn,
    input  buzzer, ringing, snoozing, snoozeNum
  );

  modport slave (
    input  timeData, alarmData, halfSecond, oneMinute, alarmEnable, snoozeBtn, stopBtn,
    output buzzer, ringing, snoozing, snoozeNum
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: arm, ring with auto give-up, stop, and optional snooze.
// Snooze support is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl #(
  parameter int unsigned RING_MIN   = 5,
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  alarm_ctrl_if.slave bus
);

  localparam int unsigned RING_W = $clog2(RING_MIN + 1);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_MIN - 1);
  localparam logic [RING_W-1:0] RING_TOP  = RING_W'(RING_MIN);

  typedef enum logic [2:0] {OFF, ARMED, RINGING, SNOOZE, DONE} state_t;

  state_t              state_q, state_d;
  logic                buzzer_q, buzzer_d;
  logic [RING_W-1:0]   ring_cnt_q, ring_cnt_d;
  logic                stop_q;
  logic                stop_edge;
  logic                match;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SNZ_W = $clog2(SNOOZE_MIN + 1);
  localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_MIN);
  localparam logic [3:0]       SNUM_MAX = 4'(MAX_SNOOZE);

  logic                snz_q;
  logic                snz_edge;
  logic [SNZ_W-1:0]    snz_cnt_q, snz_cnt_d;
  logic [3:0]          snum_q, snum_d;

  assign snz_edge     = bus.snoozeBtn & ~snz_q;
  assign bus.snoozing = (state_q == SNOOZE);
  assign bus.snoozeNum = snum_q;
`else
  logic unused_snooze;
  assign unused_snooze = bus.snoozeBtn;
  assign bus.snoozing  = 1'b0;
  assign bus.snoozeNum = '0;
`endif

  assign match       = (bus.timeData == bus.alarmData);
  assign stop_edge   = bus.stopBtn & ~stop_q;
  assign bus.ringing = (state_q == RINGING);
  assign bus.buzzer  = buzzer_q;

  always_comb begin
    state_d    = state_q;
    buzzer_d   = buzzer_q;
    ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
    snum_d     = snum_q;
`endif
    if (!bus.alarmEnable) begin
      state_d  = OFF;
      buzzer_d = 1'b0;
    end else begin
      case (state_q)
        OFF: state_d = DONE;
        ARMED: begin
          if (match) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
            buzzer_d   = 1'b1;
`ifdef ALARM_SNOOZE_EN
            snum_d     = '0;
`endif
          end
        end
        RINGING: begin
          // Exits take priority over tick activity; stop beats snooze.
          if (stop_edge) begin
            state_d  = DONE;
            buzzer_d = 1'b0;
          end else if (bus.oneMinute && ring_cnt_q >= RING_LAST) begin
            state_d    = DONE;
            buzzer_d   = 1'b0;
            ring_cnt_d = RING_TOP;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snz_edge && snum_q < SNUM_MAX) begin
            state_d   = SNOOZE;
            buzzer_d  = 1'b0;
            snum_d    = snum_q + 4'd1;
            snz_cnt_d = SNZ_LOAD;
          end
`endif
          else begin
            if (bus.halfSecond) buzzer_d = ~buzzer_q;
            if (bus.oneMinute && ring_cnt_q < RING_TOP) ring_cnt_d = ring_cnt_q + RING_W'(1);
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop_edge) begin
            state_d = DONE;
          end else if (bus.oneMinute) begin
            if (snz_cnt_q <= SNZ_W'(1)) begin
              state_d    = RINGING;
              snz_cnt_d  = '0;
              ring_cnt_d = '0;
              buzzer_d   = 1'b1;
            end else begin
              snz_cnt_d = snz_cnt_q - SNZ_W'(1);
            end
          end
        end
`endif
        DONE: if (!match) state_d = ARMED;
        default: begin
          state_d  = OFF;
          buzzer_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OFF;
      buzzer_q   <= 1'b0;
      ring_cnt_q <= '0;
      stop_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_q      <= 1'b0;
      snz_cnt_q  <= '0;
      snum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buzzer_q   <= buzzer_d;
      ring_cnt_q <= ring_cnt_d;
      stop_q     <= bus.stopBtn;
`ifdef ALARM_SNOOZE_EN
      snz_q      <= bus.snoozeBtn;
      snz_cnt_q  <= snz_cnt_d;
      snum_q     <= snum_d;
`endif
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios then random ticks/buttons against a behavioural model.
module tb_alarm_ctrl;
  localparam int RING_MIN   = 5;
  localparam int SNOOZE_MIN = 9;
  localparam int MAX_SNOOZE = 3;

  localparam int M_OFF = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3, M_DONE = 4;

  logic clk;
  logic rst_n;
  alarm_ctrl_if bus ();

  alarm_ctrl #(.RING_MIN(RING_MIN), .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  int m_mode, m_rung, m_left, m_used;
  bit m_bell, m_stop_prev, m_snz_prev;

  function void model_reset();
    m_mode = M_OFF; m_rung = 0; m_left = 0; m_used = 0;
    m_bell = 0; m_stop_prev = 0; m_snz_prev = 0;
  endfunction

  function void model_step();
    bit stop_e, snz_e, hit;
    stop_e = bus.stopBtn && !m_stop_prev;
`ifdef ALARM_SNOOZE_EN
    snz_e = bus.snoozeBtn && !m_snz_prev;
`else
    snz_e = 0;
`endif
    hit = (bus.timeData == bus.alarmData);
    m_stop_prev = bus.stopBtn;
    m_snz_prev  = bus.snoozeBtn;
    if (!bus.alarmEnable) begin
      m_mode = M_OFF; m_bell = 0;
      return;
    end
    if (m_mode == M_OFF) m_mode = M_DONE;
    else if (m_mode == M_DONE) begin
      if (!hit) m_mode = M_ARMED;
    end else if (m_mode == M_ARMED) begin
      if (hit) begin m_mode = M_RING; m_rung = 0; m_used = 0; m_bell = 1; end
    end else if (m_mode == M_RING) begin
      if (stop_e) begin m_mode = M_DONE; m_bell = 0; end
      else if (bus.oneMinute && m_rung + 1 >= RING_MIN) begin m_mode = M_DONE; m_bell = 0; end
      else if (snz_e && m_used < MAX_SNOOZE) begin
        m_mode = M_SNZ; m_bell = 0; m_used++; m_left = SNOOZE_MIN;
      end else begin
        if (bus.halfSecond) m_bell = !m_bell;
        if (bus.oneMinute) m_rung++;
      end
    end else begin
      if (stop_e) m_mode = M_DONE;
      else if (bus.oneMinute) begin
        m_left--;
        if (m_left == 0) begin m_mode = M_RING; m_rung = 0; m_bell = 1; end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("ringing",   16'(bus.ringing),   16'(m_mode == M_RING));
    chk("snoozing",  16'(bus.snoozing),  16'(m_mode == M_SNZ));
    chk("buzzer",    16'(bus.buzzer),    16'(m_bell));
    chk("snoozeNum", 16'(bus.snoozeNum), 16'(m_used));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic pulse_min();
    bus.oneMinute = 1; step(); bus.oneMinute = 0;
  endtask

  task automatic pulse_half();
    bus.halfSecond = 1; step(); bus.halfSecond = 0;
  endtask

  // Leave the matching minute and come back so the alarm fires again.
  task automatic rearm_ring();
    bus.timeData = 16'h0701; step();
    bus.timeData = 16'h0700; step();
    chk("rearm_ring", 16'(bus.ringing), 16'd1);
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 0;
    #1;
    model_reset();
    chk({tag, "_buzzer"},   16'(bus.buzzer),    16'd0);
    chk({tag, "_ringing"},  16'(bus.ringing),   16'd0);
    chk({tag, "_snoozing"}, 16'(bus.snoozing),  16'd0);
    chk({tag, "_snum"},     16'(bus.snoozeNum), 16'd0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    logic [15:0] times [3];
    int r;
    times[0] = 16'h0659; times[1] = 16'h0700; times[2] = 16'h0701;

    rst_n = 0;
    bus.timeData = 16'h0659; bus.alarmData = 16'h0700;
    bus.halfSecond = 0; bus.oneMinute = 0; bus.alarmEnable = 0;
    bus.snoozeBtn = 0; bus.stopBtn = 0;
    model_reset();
    #2;
    check_model();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // Enable, arm, trigger at 07:00.
    bus.alarmEnable = 1; step();
    step();
    bus.timeData = 16'h0700; step();
    chk("ring_on", 16'(bus.ringing), 16'd1);
    chk("buzz_on", 16'(bus.buzzer), 16'd1);
    pulse_half(); chk("toggle1", 16'(bus.buzzer), 16'd0);
    step();
    pulse_half(); chk("toggle2", 16'(bus.buzzer), 16'd1);

    // Stop, held button, no retrigger inside the minute.
    bus.stopBtn = 1; step();
    chk("stop_buzz", 16'(bus.buzzer), 16'd0);
    chk("stop_ring", 16'(bus.ringing), 16'd0);
    for (int i = 0; i < 4; i++) step();
    bus.stopBtn = 0; step();
    chk("no_retrig", 16'(bus.ringing), 16'd0);

    // Auto give-up after RING_MIN minutes.
    rearm_ring();
    for (int i = 0; i < RING_MIN; i++) begin
      pulse_min(); step();
      chk("giveup", 16'(bus.ringing), 16'(i < RING_MIN - 1));
    end

`ifdef ALARM_SNOOZE_EN
    rearm_ring();
    for (int p = 0; p < 4; p++) begin
      bus.snoozeBtn = 1; step(); bus.snoozeBtn = 0; step();
      if (p < MAX_SNOOZE) begin
        chk("snz_state", 16'(bus.snoozing), 16'd1);
        chk("snz_num", 16'(bus.snoozeNum), 16'(p + 1));
        for (int m = 0; m < SNOOZE_MIN; m++) begin pulse_min(); step(); end
        chk("snz_back", 16'(bus.ringing), 16'd1);
      end else begin
        chk("snz_ignored", 16'(bus.ringing), 16'd1);
        chk("snz_max", 16'(bus.snoozeNum), 16'(MAX_SNOOZE));
      end
    end
    bus.stopBtn = 1; step(); bus.stopBtn = 0; step();

    // Stop and snooze together, with one snooze already used.
    rearm_ring();
    bus.snoozeBtn = 1; step(); bus.snoozeBtn = 0;
    for (int m = 0; m < SNOOZE_MIN; m++) begin pulse_min(); step(); end
    bus.stopBtn = 1; bus.snoozeBtn = 1; step();
    chk("both_done", 16'(bus.ringing | bus.snoozing), 16'd0);
    chk("both_num", 16'(bus.snoozeNum), 16'd1);
    bus.stopBtn = 0; bus.snoozeBtn = 0; step();

    rearm_ring();
    bus.snoozeBtn = 1; step(); bus.snoozeBtn = 0;
    pulse_min(); step();
    async_reset_check("rst_snz");
    bus.alarmEnable = 1; step();
`else
    rearm_ring();
    bus.snoozeBtn = 1; step(); bus.snoozeBtn = 0; step();
    chk("snz_disabled", 16'(bus.ringing), 16'd1);
    bus.stopBtn = 1; step(); bus.stopBtn = 0; step();
`endif

    rearm_ring();
    async_reset_check("rst_ring");
    bus.alarmEnable = 1; step();
    rearm_ring();
    bus.alarmEnable = 0; step();
    chk("disable_off", 16'(bus.ringing | bus.buzzer), 16'd0);
    bus.alarmEnable = 1; step(); step();
    chk("enable_in_minute", 16'(bus.ringing), 16'd0);

    // Random ticks, buttons, time changes and enables; one event per cycle.
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      bus.halfSecond = 0; bus.oneMinute = 0;
      if (r < 20) bus.halfSecond = 1;
      else if (r < 40) bus.oneMinute = 1;
      else if (r < 48) bus.stopBtn = ~bus.stopBtn;
      else if (r < 58) bus.snoozeBtn = ~bus.snoozeBtn;
      else if (r < 66) bus.timeData = times[$urandom_range(0, 2)];
      else if (r < 67) bus.alarmEnable = 0;
      else if (r < 72) bus.alarmEnable = 1;
      step();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_MIN, default 5: minutes of ringing before automatic give-up.
REQ-002 Parameter SNOOZE_MIN, default 9: snooze length in minutes.
REQ-003 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event.
REQ-004 Clock is clk, reset is rst_n; one clock domain; rst_n SHALL be asynchronous and active-low.
REQ-005 clk  in  1  system clock, all state on posedge.
REQ-006 rst_n  in  1  async active-low reset.
REQ-007 timeData  in  16  current time, BCD HH:MM, [15:8] hours, [7:0] minutes.
REQ-008 alarmData  in  16  alarm time, same BCD format.
REQ-009 halfSecond  in  1  one-clk pulse every 0.5 s.
REQ-010 oneMinute  in  1  one-clk pulse every minute.
REQ-011 alarmEnable  in  1  level; 0 disarms alarm.
REQ-012 snoozeBtn  in  1  level, synchronous, debounced upstream.
REQ-013 stopBtn  in  1  level, synchronous, debounced upstream.
REQ-014 buzzer  out  1  registered buzzer drive.
REQ-015 ringing  out  1  high in RINGING.
REQ-016 snoozing  out  1  high in SNOOZE.
REQ-017 snoozeNum  out  4  snoozes used in current alarm event.

Function
REQ-018 Buttons SHALL act on rising edge only, detected internally with one register per button; a held button SHALL act once.
REQ-019 match SHALL be the full 16-bit equality timeData == alarmData, evaluated every cycle.
REQ-020 FSM states SHALL be OFF, ARMED, RINGING, SNOOZE, DONE.
REQ-021 Any state with alarmEnable=0 SHALL go to OFF next cycle; this has highest priority.
REQ-022 OFF -> DONE when alarmEnable=1, so an alarm enabled inside its matching minute does not ring.
REQ-023 ARMED -> RINGING on match; ringCnt cleared, snoozeNum cleared, buzzer set to 1 the same edge.
REQ-024 RINGING: buzzer SHALL toggle on each halfSecond pulse; ringCnt increments on each oneMinute pulse.
REQ-025 RINGING -> DONE on stop edge, or when a oneMinute pulse brings ringCnt to RING_MIN.
REQ-026 RINGING -> SNOOZE on snooze edge when snoozeNum < MAX_SNOOZE; snoozeNum increments, snzCnt loads SNOOZE_MIN; snooze edges at snoozeNum = MAX_SNOOZE SHALL be ignored.
REQ-027 Stop and snooze edges in the same cycle: stop SHALL win.
REQ-028 SNOOZE: snzCnt decrements on each oneMinute pulse; when a pulse brings it to 0, go to RINGING with ringCnt cleared and buzzer = 1; stop edge -> DONE.
REQ-029 DONE -> ARMED when match = 0, so the alarm cannot retrigger within the same minute.
REQ-030 buzzer SHALL be 0 in every state except RINGING, cleared on the transition edge out of RINGING.
REQ-031 ringing and snoozing SHALL be decoded from the state register, with no combinational path from inputs.
REQ-032 snoozeNum SHALL hold its value through DONE and ARMED, clearing only on the next ARMED -> RINGING.
REQ-033 Counters SHALL saturate, never wrap; ringCnt and snzCnt widths SHALL fit their parameters.

Reset
REQ-034 On rst_n low, state SHALL be OFF; buzzer, snoozeNum, ringCnt, snzCnt and button edge registers SHALL be 0, with all outputs 0.
REQ-035 Reset mid-RINGING or mid-SNOOZE SHALL silence the buzzer immediately (asynchronously); after release, the first active edge evaluates from OFF.

Configuration
REQ-036 Macro ALARM_SNOOZE_EN: when defined, snooze behaves per REQ-026/028.
REQ-037 When ALARM_SNOOZE_EN is undefined: snoozeBtn ignored, SNOOZE unreachable, snoozing and snoozeNum tied 0, and snooze counter logic not instantiated.

Verification
REQ-038 alarmEnable=1, alarmData=16'h0700, timeData steps 16'h0659->16'h0700 -> ringing=1 the next edge, buzzer toggles every halfSecond pulse.
REQ-039 Ringing, stopBtn pulse -> buzzer=0 and state DONE next edge; no retrigger while timeData=16'h0700; timeData=16'h0701 -> ARMED.
REQ-040 Ringing, 5 oneMinute pulses, no buttons -> DONE after the 5th pulse.
REQ-041 ALARM_SNOOZE_EN defined: 4 snooze presses, each followed by 9 oneMinute pulses -> snoozeNum reaches 3, 4th press ignored, still ringing.
REQ-042 Stop and snooze edges in the same cycle while ringing -> DONE, snoozeNum unchanged.
REQ-043 rst_n=0 mid-SNOOZE -> all outputs 0 immediately; alarmEnable=0 during RINGING -> OFF next edge.
